hazard_fwd_ctrl: RTL and testbench

- Sequencing controller for the 5-stage pipeline (PC/nPC registers, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards and inserts one bubble:
  - drives the control-signal NOP mux select;
  - freezes PC, nPC and IF/ID.
- Generates ID-stage operand forwarding selects and the PC-source select for taken conditional/unconditional transfers (delay-slot architecture, no flush).
- Keeps saturating stall and taken-transfer counters for the bench printout.

---
 rtl/hazard_fwd_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline sequencing controller: load-use bubble insertion, ID-stage operand
// forwarding selects, transfer PC-source select and saturating event counters.
module hazard_fwd_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_ta_instr,
    input  logic             ID_cond_true,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_rf_enable,
    input  logic             EX_load_instr,
    input  logic [REG_W-1:0] MEM_rd,
    input  logic             MEM_rf_enable,
    input  logic [REG_W-1:0] WB_rd,
    input  logic             WB_rf_enable,
    output logic             pc_le,
    output logic             npc_le,
    output logic             ifid_le,
    output logic             nop_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_src,
    output logic             stalling,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] ta_cnt
);

    typedef enum logic {RUN, STALL} state_t;

    state_t state, state_nxt;
    logic   lu_hz;
    logic   hz_rs, hz_rt;

    assign hz_rs = ID_uses_rs && (ID_rs == EX_rd);
    assign hz_rt = ID_uses_rt && (ID_rt == EX_rd);
    assign lu_hz = EX_load_instr && EX_rf_enable && (EX_rd != '0) && (hz_rs || hz_rt);

    // Forwarding source for one operand; a load in EX can only ever be
    // consumed after the bubble, so it is skipped while the hazard stands.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             used,
        input logic             ex_ok
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != '0) begin
            if (ex_ok && EX_rf_enable && EX_rd == src)
                sel = 2'b01;
            else if (MEM_rf_enable && MEM_rd == src)
                sel = 2'b10;
            else if (WB_rf_enable && WB_rd == src)
                sel = 2'b11;
        end
        return sel;
    endfunction

    logic ex_ok;
    assign ex_ok = !(EX_load_instr && lu_hz);
    assign fwd_a = fwd_sel(ID_rs, ID_uses_rs, ex_ok);
    assign fwd_b = fwd_sel(ID_rt, ID_uses_rt, ex_ok);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_nxt = state;
        nop_sel   = 1'b0;
        pc_le     = 1'b1;
        npc_le    = 1'b1;
        ifid_le   = 1'b1;
        pc_src    = ID_ta_instr && ID_cond_true;
        case (state)
            RUN, STALL: begin
                if (lu_hz) begin
                    nop_sel   = 1'b1;
                    pc_le     = 1'b0;
                    npc_le    = 1'b0;
                    ifid_le   = 1'b0;
                    pc_src    = 1'b0;
                    state_nxt = STALL;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= '0;
            ta_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (nop_sel && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (pc_src && pc_le && ta_cnt != '1)
                ta_cnt <= ta_cnt + CNT_W'(1);
        end
    end

    assign stalling = (state == STALL);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios then random
// cycles, all compared against a rule-level reference model.
module tb_hazard_fwd_ctrl;
    localparam int CNT_W = 4;
    localparam int REG_W = 5;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [REG_W-1:0] ID_rs, ID_rt, EX_rd, MEM_rd, WB_rd;
    logic ID_uses_rs, ID_uses_rt, ID_ta_instr, ID_cond_true;
    logic EX_rf_enable, EX_load_instr, MEM_rf_enable, WB_rf_enable;
    logic pc_le, npc_le, ifid_le, nop_sel, pc_src, stalling;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, ta_cnt;

    hazard_fwd_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_ta_instr(ID_ta_instr), .ID_cond_true(ID_cond_true),
        .EX_rd(EX_rd), .EX_rf_enable(EX_rf_enable), .EX_load_instr(EX_load_instr),
        .MEM_rd(MEM_rd), .MEM_rf_enable(MEM_rf_enable),
        .WB_rd(WB_rd), .WB_rf_enable(WB_rf_enable),
        .pc_le(pc_le), .npc_le(npc_le), .ifid_le(ifid_le), .nop_sel(nop_sel),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_src(pc_src), .stalling(stalling),
        .stall_cnt(stall_cnt), .ta_cnt(ta_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: plain integers, saturating by comparison.
    bit m_stall;
    int m_scnt, m_tcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m_hazard();
        return EX_load_instr && EX_rf_enable && EX_rd != 0 &&
               ((ID_uses_rs && ID_rs == EX_rd) || (ID_uses_rt && ID_rt == EX_rd));
    endfunction

    function automatic int m_fwd(input int src, input bit used);
        if (!used || src == 0) return 0;
        if (EX_rf_enable && EX_rd == src && !(EX_load_instr && m_hazard())) return 1;
        if (MEM_rf_enable && MEM_rd == src) return 2;
        if (WB_rf_enable && WB_rd == src) return 3;
        return 0;
    endfunction

    task automatic zero_inputs();
        {ID_rs, ID_rt, EX_rd, MEM_rd, WB_rd} = '0;
        {ID_uses_rs, ID_uses_rt, ID_ta_instr, ID_cond_true} = '0;
        {EX_rf_enable, EX_load_instr, MEM_rf_enable, WB_rf_enable} = '0;
    endtask

    // One clock: inputs are already driven; check combinational outputs
    // mid-low-phase, clock, then check registered outputs after the edge.
    task automatic cycle(input string tag);
        bit hz, take;
        #1;
        hz   = m_hazard();
        take = ID_ta_instr && ID_cond_true && !hz;
        check({tag, ".nop_sel"}, nop_sel, hz);
        check({tag, ".pc_le"},   pc_le,   !hz);
        check({tag, ".npc_le"},  npc_le,  !hz);
        check({tag, ".ifid_le"}, ifid_le, !hz);
        check({tag, ".pc_src"},  pc_src,  take);
        check({tag, ".fwd_a"},   fwd_a,   m_fwd(ID_rs, ID_uses_rs));
        check({tag, ".fwd_b"},   fwd_b,   m_fwd(ID_rt, ID_uses_rt));
        @(posedge clk);
        if (reset) begin
            m_stall = 0; m_scnt = 0; m_tcnt = 0;
        end else begin
            m_stall = hz;
            if (hz && m_scnt < SAT) m_scnt++;
            if (take && m_tcnt < SAT) m_tcnt++;
        end
        #1;
        check({tag, ".stalling"},  stalling,  m_stall);
        check({tag, ".stall_cnt"}, stall_cnt, m_scnt);
        check({tag, ".ta_cnt"},    ta_cnt,    m_tcnt);
        @(negedge clk);
    endtask

    initial begin
        zero_inputs();
        reset = 1'b1;
        @(negedge clk);
        cycle("reset0");
        cycle("reset1");
        reset = 1'b0;

        // Load-use on r5: one bubble, then MEM forwarding.
        EX_load_instr = 1; EX_rf_enable = 1; EX_rd = 5; ID_rs = 5; ID_uses_rs = 1;
        #1 check("lu.nop_sel_lit", nop_sel, 1'b1);
        cycle("lu_c1");
        check("lu.stalling_lit", stalling, 1'b1);
        EX_load_instr = 0; EX_rf_enable = 0; EX_rd = 0; MEM_rd = 5; MEM_rf_enable = 1;
        #1 check("lu.fwd_a_lit", fwd_a, 2'b10);
        check("lu.pc_le_lit", pc_le, 1'b1);
        cycle("lu_c2");
        check("lu.stall_cnt_lit", stall_cnt, 4'd1);
        check("lu.run_lit", stalling, 1'b0);

        // ALU producer priority chain on operand B.
        zero_inputs();
        EX_rd = 3; MEM_rd = 3; WB_rd = 3; EX_rf_enable = 1; MEM_rf_enable = 1; WB_rf_enable = 1;
        ID_rt = 3; ID_uses_rt = 1;
        #1 check("prio.ex_lit", fwd_b, 2'b01);
        cycle("prio_ex");
        EX_rf_enable = 0;
        #1 check("prio.mem_lit", fwd_b, 2'b10);
        cycle("prio_mem");
        MEM_rf_enable = 0;
        #1 check("prio.wb_lit", fwd_b, 2'b11);
        cycle("prio_wb");
        WB_rf_enable = 0;
        #1 check("prio.rf_lit", fwd_b, 2'b00);
        cycle("prio_rf");

        // r0 is never a hazard nor a forwarding source.
        zero_inputs();
        EX_rd = 0; EX_load_instr = 1; EX_rf_enable = 1; ID_rs = 0; ID_uses_rs = 1;
        #1 check("r0.nop_sel_lit", nop_sel, 1'b0);
        check("r0.fwd_a_lit", fwd_a, 2'b00);
        cycle("r0");

        // Taken / not-taken transfer.
        zero_inputs();
        ID_ta_instr = 1; ID_cond_true = 1;
        #1 check("br.pc_src_lit", pc_src, 1'b1);
        cycle("br_taken");
        check("br.ta_cnt_lit", ta_cnt, 4'd1);
        ID_cond_true = 0;
        cycle("br_not_taken");
        check("br.ta_cnt_hold_lit", ta_cnt, 4'd1);

        // JR r7 behind a load of r7: blocked, then taken via MEM forward.
        zero_inputs();
        ID_ta_instr = 1; ID_cond_true = 1; ID_rs = 7; ID_uses_rs = 1;
        EX_load_instr = 1; EX_rf_enable = 1; EX_rd = 7;
        #1 check("jr.c1_pc_src_lit", pc_src, 1'b0);
        check("jr.c1_nop_lit", nop_sel, 1'b1);
        cycle("jr_c1");
        EX_load_instr = 0; EX_rf_enable = 0; EX_rd = 0; MEM_rd = 7; MEM_rf_enable = 1;
        #1 check("jr.c2_pc_src_lit", pc_src, 1'b1);
        check("jr.c2_fwd_a_lit", fwd_a, 2'b10);
        cycle("jr_c2");

        // Reset while in STALL.
        zero_inputs();
        EX_load_instr = 1; EX_rf_enable = 1; EX_rd = 9; ID_rt = 9; ID_uses_rt = 1;
        cycle("pre_rst");
        reset = 1;
        #1 check("rst.comb_nop_lit", nop_sel, 1'b1);
        cycle("rst_in_stall");
        check("rst.stalling_lit", stalling, 1'b0);
        check("rst.stall_cnt_lit", stall_cnt, 4'd0);
        check("rst.ta_cnt_lit", ta_cnt, 4'd0);
        reset = 0;

        // Persistent hazard saturates stall_cnt.
        for (int i = 0; i < SAT + 3; i++) cycle("sat");
        check("sat.stall_cnt_lit", stall_cnt, 4'hF);
        check("sat.stalling_lit", stalling, 1'b1);

        // Randomized cycles over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            ID_rs = REG_W'($urandom_range(0, 7));
            ID_rt = REG_W'($urandom_range(0, 7));
            EX_rd = REG_W'($urandom_range(0, 7));
            MEM_rd = REG_W'($urandom_range(0, 7));
            WB_rd = REG_W'($urandom_range(0, 7));
            {ID_uses_rs, ID_uses_rt, ID_ta_instr, ID_cond_true} = 4'($urandom);
            {EX_rf_enable, EX_load_instr, MEM_rf_enable, WB_rf_enable} = 4'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
